// File: rtl/video_timing_gen_if.sv
`timescale 1ns/1ps
// Pixel-stream bundle (sync, enable, 24-bit {B,G,R} data, frame-start pulse).
// The source drives it through master; overlay/processing blocks consume it through slave.
interface video_timing_gen_if;
  logic        o1_vs;
  logic        o1_hs;
  logic        o1_de;
  logic [23:0] o1_data;
  logic        o1_fstart;

  modport master (output o1_vs, o1_hs, o1_de, o1_data, o1_fstart);
  modport slave  (input  o1_vs, o1_hs, o1_de, o1_data, o1_fstart);
endinterface

// File: rtl/video_timing_gen.sv
`timescale 1ns/1ps
// Programmable raster timing source with frame-aligned start/stop and a frame counter.
// Define VIDEO_TIMING_GEN_PATTERN_EN to emit 8 colour bars instead of the constant i_bgr.
module video_timing_gen #(
  parameter int P_HACT   = 1280,
  parameter int P_HFP    = 110,
  parameter int P_HSYNC  = 40,
  parameter int P_HBP    = 220,
  parameter int P_VACT   = 720,
  parameter int P_VFP    = 5,
  parameter int P_VSYNC  = 5,
  parameter int P_VBP    = 20,
  parameter bit P_HS_POL = 1'b1,
  parameter bit P_VS_POL = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_xres,
  input  logic                      i_en,
  input  logic [23:0]               i_bgr,
  video_timing_gen_if.master        vid,
  output logic [15:0]               o_fcnt,
  output logic                      o_busy
);

  localparam int HTOTAL = P_HACT + P_HFP + P_HSYNC + P_HBP;
  localparam int VTOTAL = P_VACT + P_VFP + P_VSYNC + P_VBP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(P_HACT);
  localparam logic [HW-1:0] HS_BEG = HW'(P_HACT + P_HFP);
  localparam logic [HW-1:0] HS_END = HW'(P_HACT + P_HFP + P_HSYNC);
  localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(P_VACT);
  localparam logic [VW-1:0] VS_BEG = VW'(P_VACT + P_VFP);
  localparam logic [VW-1:0] VS_END = VW'(P_VACT + P_VFP + P_VSYNC);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic [VW-1:0] vcnt, vcnt_nxt;
  logic          frame_end;
  logic          running;
  logic          de_c, hs_c, vs_c;
  logic [23:0]   pix_data;

  assign running = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_xres) begin
    if (!i_xres) begin
      state <= IDLE;
      hcnt  <= '0;
      vcnt  <= '0;
    end else begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
      vcnt  <= vcnt_nxt;
    end
  end

  // STOP only differs from RUN in that the frame in flight is the last one unless i_en returns.
  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    vcnt_nxt  = vcnt;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        hcnt_nxt = '0;
        vcnt_nxt = '0;
        if (i_en) state_nxt = RUN;
      end
      RUN, STOP: begin
        frame_end = (hcnt == H_LAST) && (vcnt == V_LAST);
        if (hcnt == H_LAST) begin
          hcnt_nxt = '0;
          vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
        if (frame_end) state_nxt = i_en ? RUN : IDLE;
        else           state_nxt = i_en ? RUN : STOP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign de_c = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign hs_c = (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vs_c = (vcnt >= VS_BEG) && (vcnt < VS_END);

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  localparam int BAR_W = P_HACT / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  logic [2:0]    bar_idx;
  logic [BW-1:0] bar_pix;
  logic          unused_bgr;

  assign unused_bgr = ^i_bgr;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'h00FFFF;
      3'd2:    return 24'hFFFF00;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'h0000FF;
      3'd6:    return 24'hFF0000;
      default: return 24'h000000;
    endcase
  endfunction

  // Bar position tracks hcnt cycle for cycle, restarting with every line.
  always_ff @(posedge i_clk or negedge i_xres) begin
    if (!i_xres) begin
      bar_idx <= '0;
      bar_pix <= '0;
    end else if (!running || hcnt == H_LAST) begin
      bar_idx <= '0;
      bar_pix <= '0;
    end else if (bar_pix == BAR_LAST) begin
      bar_idx <= bar_idx + 3'd1;
      bar_pix <= '0;
    end else begin
      bar_pix <= bar_pix + 1'b1;
    end
  end

  assign pix_data = bar_colour(bar_idx);
`else
  assign pix_data = i_bgr;
`endif

  always_ff @(posedge i_clk or negedge i_xres) begin
    if (!i_xres) begin
      vid.o1_de     <= 1'b0;
      vid.o1_data   <= '0;
      vid.o1_fstart <= 1'b0;
      vid.o1_hs     <= ~P_HS_POL;
      vid.o1_vs     <= ~P_VS_POL;
      o_fcnt        <= '0;
      o_busy        <= 1'b0;
    end else begin
      o_busy <= running;
      if (frame_end) o_fcnt <= o_fcnt + 16'd1;
      if (running) begin
        vid.o1_de     <= de_c;
        vid.o1_data   <= de_c ? pix_data : 24'h000000;
        vid.o1_fstart <= (hcnt == '0) && (vcnt == '0);
        vid.o1_hs     <= hs_c ? P_HS_POL : ~P_HS_POL;
        vid.o1_vs     <= vs_c ? P_VS_POL : ~P_VS_POL;
      end else begin
        vid.o1_de     <= 1'b0;
        vid.o1_data   <= '0;
        vid.o1_fstart <= 1'b0;
        vid.o1_hs     <= ~P_HS_POL;
        vid.o1_vs     <= ~P_VS_POL;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
`timescale 1ns/1ps
// Testbench for video_timing_gen: random i_en/i_bgr against a frame-position reference model,
// plus an inverted-polarity instance and an asynchronous mid-line reset.
module tb_video_timing_gen;

  localparam int HACT = 16, HFP = 2, HSYNC = 3, HBP = 3;
  localparam int VACT = 4,  VFP = 1, VSYNC = 2, VBP = 1;
  localparam int HTOTAL = HACT + HFP + HSYNC + HBP;
  localparam int VTOTAL = VACT + VFP + VSYNC + VBP;
  localparam int FRAME  = HTOTAL * VTOTAL;

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
                                      24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};
`endif

  logic        clk = 1'b0;
  logic        xres;
  logic        en;
  logic [23:0] bgr;
  logic [15:0] fcnt, fcnt_n;
  logic        busy, busy_n;

  video_timing_gen_if vid ();
  video_timing_gen_if vid_n ();

  always #5 clk = ~clk;

  video_timing_gen #(
    .P_HACT(HACT), .P_HFP(HFP), .P_HSYNC(HSYNC), .P_HBP(HBP),
    .P_VACT(VACT), .P_VFP(VFP), .P_VSYNC(VSYNC), .P_VBP(VBP),
    .P_HS_POL(1'b1), .P_VS_POL(1'b1)
  ) dut (
    .i_clk(clk), .i_xres(xres), .i_en(en), .i_bgr(bgr),
    .vid(vid), .o_fcnt(fcnt), .o_busy(busy)
  );

  video_timing_gen #(
    .P_HACT(HACT), .P_HFP(HFP), .P_HSYNC(HSYNC), .P_HBP(HBP),
    .P_VACT(VACT), .P_VFP(VFP), .P_VSYNC(VSYNC), .P_VBP(VBP),
    .P_HS_POL(1'b0), .P_VS_POL(1'b0)
  ) dut_n (
    .i_clk(clk), .i_xres(xres), .i_en(en), .i_bgr(bgr),
    .vid(vid_n), .o_fcnt(fcnt_n), .o_busy(busy_n)
  );

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int prev_fs  = -1;

  // Reference model: frame position of the pixel the counters present, -1 when idle.
  int          pos = -1;
  logic        e_vs, e_hs, e_de, e_fs, e_busy;
  logic [23:0] e_data;
  logic [15:0] e_fcnt;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h cycle=%0d", tag, obs, expv, cycle);
    end
  endtask

  function automatic logic [23:0] expColour(input int px);
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    return BARS[px / (HACT / 8)];
`else
    return bgr;
`endif
  endfunction

  task automatic modelReset();
    pos    = -1;
    e_fcnt = '0;
    e_vs   = 1'b0; e_hs = 1'b0; e_de = 1'b0; e_fs = 1'b0;
    e_data = '0;   e_busy = 1'b0;
    prev_fs = -1;
  endtask

  // Expected outputs after the coming clock edge, then advance the frame position.
  task automatic modelStep(input bit en_s);
    int line, px;
    e_busy = (pos >= 0);
    if (pos >= 0) begin
      line   = pos / HTOTAL;
      px     = pos % HTOTAL;
      e_de   = (px < HACT) && (line < VACT);
      e_hs   = (px >= HACT + HFP) && (px < HACT + HFP + HSYNC);
      e_vs   = (line >= VACT + VFP) && (line < VACT + VFP + VSYNC);
      e_fs   = (pos == 0);
      e_data = e_de ? expColour(px) : 24'h000000;
    end else begin
      e_vs = 1'b0; e_hs = 1'b0; e_de = 1'b0; e_fs = 1'b0; e_data = '0;
    end
    if (pos < 0) begin
      pos = en_s ? 0 : -1;
    end else if (pos == FRAME - 1) begin
      e_fcnt = e_fcnt + 16'd1;
      pos    = en_s ? 0 : -1;
    end else begin
      pos++;
    end
  endtask

  task automatic compareAll();
    checkOutput("sync", 32'({vid.o1_vs, vid.o1_hs, vid.o1_de, vid.o1_fstart}),
                32'({e_vs, e_hs, e_de, e_fs}));
    checkOutput("data", 32'(vid.o1_data), 32'(e_data));
    checkOutput("fcnt", 32'(fcnt), 32'(e_fcnt));
    checkOutput("busy", 32'(busy), 32'(e_busy));
    checkOutput("sync_lowpol", 32'({vid_n.o1_vs, vid_n.o1_hs}), 32'({~e_vs, ~e_hs}));
    if (!busy) prev_fs = -1;
    if (vid.o1_fstart) begin
      if (prev_fs >= 0) checkOutput("fstart_period", cycle - prev_fs, FRAME);
      prev_fs = cycle;
    end
  endtask

  task automatic applyStimulus(input bit en_v, input logic [23:0] bgr_v);
    @(negedge clk);
    cycle++;
    compareAll();
    en  = en_v;
    bgr = bgr_v;
    modelStep(en_v);
  endtask

  initial begin
    bit          en_r;
    logic [23:0] bgr_r;
    en_r  = 1'b1;
    bgr_r = 24'h123456;

    xres = 1'b0;
    en   = 1'b0;
    bgr  = 24'h123456;
    modelReset();
    repeat (3) @(negedge clk);
    compareAll();
    xres = 1'b1;

    // Continuous run: three whole frames.
    repeat (5) applyStimulus(1'b0, bgr_r);
    repeat (3 * FRAME + 5) applyStimulus(1'b1, bgr_r);
    checkOutput("fcnt_3frames", 32'(fcnt), 32'd3);

    // Drop i_en mid-frame, then start a frame and drop i_en at line 2.
    repeat (FRAME + 5) applyStimulus(1'b0, bgr_r);
    repeat (2 * HTOTAL + 5) applyStimulus(1'b1, bgr_r);
    repeat (FRAME + 20) applyStimulus(1'b0, bgr_r);
    checkOutput("fcnt_after_stop", 32'(fcnt), 32'd5);
    checkOutput("busy_after_stop", 32'(busy), 32'd0);

    // Re-assert i_en during STOP: the following frame must follow without a gap.
    repeat (60) applyStimulus(1'b1, bgr_r);
    repeat (30) applyStimulus(1'b0, bgr_r);
    repeat (FRAME + 10) applyStimulus(1'b1, bgr_r);

    // Random run requests and colours.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 149) == 0) en_r = ~en_r;
      if ($urandom_range(0, 99) == 0) bgr_r = 24'($urandom());
      applyStimulus(en_r, bgr_r);
    end

    // Asynchronous reset in the middle of a line.
    repeat (FRAME / 2 + 7) applyStimulus(1'b1, bgr_r);
    @(posedge clk);
    #2;
    xres = 1'b0;
    #1;
    checkOutput("arst_de", 32'(vid.o1_de), 32'd0);
    checkOutput("arst_data", 32'(vid.o1_data), 32'd0);
    checkOutput("arst_fstart", 32'(vid.o1_fstart), 32'd0);
    checkOutput("arst_hs", 32'(vid.o1_hs), 32'd0);
    checkOutput("arst_vs", 32'(vid.o1_vs), 32'd0);
    checkOutput("arst_fcnt", 32'(fcnt), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_lowpol", 32'({vid_n.o1_vs, vid_n.o1_hs}), 32'd3);
    modelReset();
    @(negedge clk);
    cycle++;
    xres = 1'b1;
    en   = 1'b1;
    modelStep(1'b1);
    repeat (FRAME + 10) applyStimulus(1'b1, bgr_r);
    checkOutput("fcnt_restart", 32'(fcnt), 32'd1);

    repeat (FRAME + 5) applyStimulus(1'b0, bgr_r);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
